// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion with an 11-entry round-key store.
// Round keys are read back in reverse order for the decryption controller.

module aes_sbox_rom (
  input  logic [7:0] addr_i,
  output logic [7:0] data_o
);

  // Forward S-box, entry i stored at bits [8*(255-i) +: 8]
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // ROM lookup
  always_comb begin
    data_o = SBOX_TABLE[{~addr_i, 3'b000} +: 8];
  end

endmodule

module aes_key_schedule (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         key_valid_i,
  input  logic [127:0] key_i,
  input  logic [3:0]   round_idx_i,
  output logic         key_ready_o,
  output logic         busy_o,
  output logic [127:0] round_key_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_e;

  state_e       state_r, state_s;
  logic [3:0]   r_r;
  logic [7:0]   rcon_r;
  logic [127:0] rk_r [0:10];
  logic         key_ready_r, busy_r;
  logic         load_s, step_s;
  logic [127:0] prev_s, next_rk_s;
  logic [31:0]  rot_s, sub_s, t_s, n0_s, n1_s, n2_s, n3_s;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Next-state and load/step strobes
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_READY: begin
        if (key_valid_i) begin
          state_s = ST_EXPAND;
          load_s  = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_EXPAND: begin
        step_s = 1'b1;
        if (r_r == 4'd10) begin
          state_s = ST_READY;
        end else begin
          state_s = ST_EXPAND;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // One expansion round: previous key, RotWord, SubWord, rcon, word chain
  always_comb begin
    prev_s    = ((r_r >= 4'd1) && (r_r <= 4'd10)) ? rk_r[r_r - 4'd1] : 128'h0;
    rot_s     = {prev_s[23:0], prev_s[31:24]};
    t_s       = sub_s ^ {rcon_r, 24'h000000};
    n0_s      = prev_s[127:96] ^ t_s;
    n1_s      = prev_s[95:64]  ^ n0_s;
    n2_s      = prev_s[63:32]  ^ n1_s;
    n3_s      = prev_s[31:0]   ^ n2_s;
    next_rk_s = {n0_s, n1_s, n2_s, n3_s};
  end

  aes_sbox_rom u_sbox0 (.addr_i(rot_s[31:24]), .data_o(sub_s[31:24]));
  aes_sbox_rom u_sbox1 (.addr_i(rot_s[23:16]), .data_o(sub_s[23:16]));
  aes_sbox_rom u_sbox2 (.addr_i(rot_s[15:8]),  .data_o(sub_s[15:8]));
  aes_sbox_rom u_sbox3 (.addr_i(rot_s[7:0]),   .data_o(sub_s[7:0]));

  // Control state, counters and registered status flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      r_r         <= 4'd0;
      rcon_r      <= 8'h00;
      key_ready_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      key_ready_r <= (state_s == ST_READY);
      busy_r      <= (state_s == ST_EXPAND);
      if (load_s) begin
        r_r    <= 4'd1;
        rcon_r <= 8'h01;
      end else if (step_s) begin
        r_r    <= r_r + 4'd1;
        rcon_r <= xtime(rcon_r);
      end
    end
  end

  // Round-key register file; r_r stays within 1..10 while stepping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 11; i++) begin
        rk_r[i] <= 128'h0;
      end
    end else if (load_s) begin
      rk_r[0] <= key_i;
    end else if (step_s) begin
      rk_r[r_r] <= next_rk_s;
    end
  end

  // Reverse-order read port for decryption
  always_comb begin
    if (round_idx_i <= 4'd10) begin
      round_key_o = rk_r[4'd10 - round_idx_i];
    end else begin
      round_key_o = 128'h0;
    end
  end

  assign key_ready_o = key_ready_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Randomized self-checking bench for aes_key_schedule against a FIPS-197 level model.
// The model derives the S-box from GF(2^8) inversion and expands keys word by word.

module tb_aes_key_schedule;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         key_valid_i = 1'b0;
  logic [127:0] key_i = 128'h0;
  logic [3:0]   round_idx_i = 4'd0;
  logic         key_ready_o, busy_o;
  logic [127:0] round_key_o;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;
  logic [7:0] sbox_m [256];

  aes_key_schedule dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .key_valid_i(key_valid_i), .key_i(key_i),
    .round_idx_i(round_idx_i), .key_ready_o(key_ready_o), .busy_o(busy_o),
    .round_key_o(round_key_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Full FIPS-197 expansion; round key k lives at bits [128*k +: 128]
  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1407:0] s;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) s[128*k +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return s;
  endfunction

  // Behavioural model: idle/ready accept a key, then 10 busy cycles
  logic          m_busy, m_ready, m_known;
  int            m_left;
  logic [127:0]  m_key;
  logic [1407:0] m_sched;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_busy <= 1'b0; m_ready <= 1'b0; m_known <= 1'b1; m_left <= 0; m_sched <= '0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0; m_ready <= 1'b1; m_known <= 1'b1; m_sched <= expand(m_key);
      end
    end else if (key_valid_i) begin
      m_busy <= 1'b1; m_ready <= 1'b0; m_known <= 1'b0; m_left <= 10; m_key <= key_i;
    end
  end

  function automatic logic [127:0] exp_rk(input logic [3:0] idx);
    if (idx <= 4'd10) return m_sched[128*(10 - int'(idx)) +: 128];
    return 128'h0;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("ready", 128'(key_ready_o), 128'(m_ready));
      check("busy", 128'(busy_o), 128'(m_busy));
      if (m_known) check("round_key", round_key_o, exp_rk(round_idx_i));
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    round_idx_i = 4'($urandom_range(0, 15));
  endtask

  task automatic pulse(input logic [127:0] key);
    key_i = key;
    key_valid_i = 1'b1;
    tick();
    key_valid_i = 1'b0;
    key_i = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!key_ready_o && n < 40) begin
      tick();
      n++;
    end
    if (!key_ready_o) check("ready_timeout", 128'(key_ready_o), 128'd1);
  endtask

  task automatic read_idx(input string name, input logic [3:0] idx, input logic [127:0] exp);
    round_idx_i = idx;
    #1;
    check(name, round_key_o, exp);
  endtask

  int n;
  logic [7:0] inv, av;
  logic [1407:0] pin_s;

  initial begin
    for (int a = 0; a < 256; a++) begin
      av = 8'(a);
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(av, 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    check("model_sbox00", 128'(sbox_m[0]), 128'h63);
    check("model_sbox53", 128'(sbox_m[8'h53]), 128'hed);
    pin_s = expand(KEY_A);
    check("model_rk1", pin_s[128*1 +: 128], 128'ha0fafe1788542cb123a339392a6c7605);
    check("model_rk10", pin_s[128*10 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset state
    tick(); tick();
    chk_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      read_idx("reset_key", 4'(i), 128'h0);
      check("reset_ready", 128'(key_ready_o), 128'd0);
      check("reset_busy", 128'(busy_o), 128'd0);
    end
    rst_ni = 1'b1;
    tick(); tick();

    // FIPS-197 key
    pulse(KEY_A);
    check("busy_after_pulse", 128'(busy_o), 128'd1);
    wait_ready(n);
    check("latency_a", 128'(n), 128'd10);
    read_idx("a_idx0", 4'd0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_idx("a_idx9", 4'd9, 128'ha0fafe1788542cb123a339392a6c7605);
    read_idx("a_idx10", 4'd10, KEY_A);
    tick(); tick();

    // Rekey from READY
    pulse(KEY_B);
    check("rekey_ready_drop", 128'(key_ready_o), 128'd0);
    wait_ready(n);
    check("latency_b", 128'(n), 128'd10);
    read_idx("b_idx0", 4'd0, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    for (int i = 11; i < 16; i++) read_idx("b_oob", 4'(i), 128'h0);
    tick();

    // Pulse during EXPAND is ignored
    pulse(KEY_A);
    tick(); tick(); tick();
    pulse(KEY_B);
    wait_ready(n);
    check("latency_ignored", 128'(n + 4), 128'd10);
    read_idx("ign_idx0", 4'd0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_idx("ign_idx10", 4'd10, KEY_A);
    tick();

    // Asynchronous reset mid-EXPAND
    pulse({$urandom, $urandom, $urandom, $urandom});
    tick(); tick(); tick(); tick();
    rst_ni = 1'b0;
    #1;
    check("arst_ready", 128'(key_ready_o), 128'd0);
    check("arst_busy", 128'(busy_o), 128'd0);
    read_idx("arst_key0", 4'd0, 128'h0);
    read_idx("arst_key10", 4'd10, 128'h0);
    tick();
    rst_ni = 1'b1;
    tick(); tick();
    check("idle_ready", 128'(key_ready_o), 128'd0);
    check("idle_busy", 128'(busy_o), 128'd0);
    pulse(KEY_B);
    wait_ready(n);
    read_idx("fresh_idx0", 4'd0, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Randomized keys, held valids and idle gaps
    for (int it = 0; it < 12; it++) begin
      key_i = {$urandom, $urandom, $urandom, $urandom};
      key_valid_i = 1'b1;
      for (int h = 0; h < int'($urandom_range(1, 3)); h++) begin
        tick();
        key_i = {$urandom, $urandom, $urandom, $urandom};
      end
      key_valid_i = 1'b0;
      wait_ready(n);
      for (int g = 0; g < int'($urandom_range(2, 8)); g++) begin
        key_valid_i = ($urandom_range(0, 7) == 0);
        key_i = {$urandom, $urandom, $urandom, $urandom};
        tick();
      end
      key_valid_i = 1'b0;
      wait_ready(n);
    end
    tick(); tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
